// File: rtl/cpu_bus_mailbox.sv
// CPU bus responder: byte mailbox with RX/TX FIFOs,
// sticky status flags, control register and registered irq.
module cpu_bus_mailbox #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_push,
  output logic        rx_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_pop,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [2:0] WS_LOAD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic commit;

  logic [7:0] rx_mem_q [DEPTH];
  logic [7:0] tx_mem_q [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
  logic [CW-1:0] rx_cnt_q, tx_cnt_q;
  logic ovr_q, ovf_q, unf_q;
  logic [1:0] ctrl_q;
  logic [31:0] rdata_q, rd_val;
  logic irq_q;

  logic unused;
  assign unused = ^{address[31:4], address[1:0], wdata[31:8]};

  // Access commits on the edge that moves into ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: if (request) begin
        if (WAIT_STATES == 0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = WS_LOAD;
        end
      end
      WAIT: if (cnt_q == 3'd0) begin
        state_d = ACK;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [1:0] sel;
  logic is_wr, rd_data, wr_data, wr_stat, wr_ctrl;
  assign sel     = address[3:2];
  assign is_wr   = |wmask;
  assign rd_data = commit & ~is_wr & (sel == 2'd1);
  assign wr_data = commit & is_wr & wmask[0] & (sel == 2'd1);
  assign wr_stat = commit & is_wr & wmask[0] & (sel == 2'd0);
  assign wr_ctrl = commit & is_wr & wmask[0] & (sel == 2'd2);

  logic rx_empty, rx_full_w, tx_empty, tx_full_w;
  assign rx_empty  = (rx_cnt_q == '0);
  assign rx_full_w = (rx_cnt_q == FULL);
  assign tx_empty  = (tx_cnt_q == '0);
  assign tx_full_w = (tx_cnt_q == FULL);

  // A pop on the same edge frees the slot for a push to a full FIFO
  logic rx_pop, rx_wr, tx_rd, tx_wr;
  assign rx_pop = rd_data & ~rx_empty;
  assign rx_wr  = rx_push & (~rx_full_w | rx_pop);
  assign tx_rd  = tx_pop & ~tx_empty;
  assign tx_wr  = wr_data & (~tx_full_w | tx_rd);

  logic ovr_d, ovf_d, unf_d;
  assign ovr_d = (rx_push & rx_full_w & ~rx_pop)
               | (ovr_q & ~(wr_stat & wdata[3]));
  assign ovf_d = (wr_data & tx_full_w & ~tx_rd)
               | (ovf_q & ~(wr_stat & wdata[4]));
  assign unf_d = (rd_data & rx_empty)
               | (unf_q & ~(wr_stat & wdata[5]));

  always_comb begin
    rd_val = '0;
    unique case (sel)
      2'd0: rd_val = {8'h0, 8'(tx_cnt_q), 8'(rx_cnt_q),
                      2'b0, unf_q, ovf_q, ovr_q,
                      tx_empty, tx_full_w, ~rx_empty};
      2'd1: if (!rx_empty) rd_val = {24'h0, rx_mem_q[rx_rp_q]};
      2'd2: rd_val = {30'h0, ctrl_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      ovr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ctrl_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (rx_wr)  rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
      if (tx_wr)  tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_rd)  tx_rp_q <= tx_rp_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_wr) - CW'(rx_pop);
      tx_cnt_q <= tx_cnt_q + CW'(tx_wr) - CW'(tx_rd);
      ovr_q    <= ovr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (wr_ctrl) ctrl_q <= wdata[1:0];
      rdata_q  <= (commit & ~is_wr) ? rd_val : 32'h0;
      irq_q    <= (ctrl_q[0] & ~rx_empty)
                | (ctrl_q[1] & tx_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wp_q] <= rx_data;
    if (tx_wr) tx_mem_q[tx_wp_q] <= wdata[7:0];
  end

  assign ack      = (state_q == ACK);
  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign rx_full  = rx_full_w;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem_q[tx_rp_q];

endmodule
